// File: rtl/mvm_seq.sv
// mvm_seq: loads an MxN matrix and N-vector, then drives a saturating MAC one row
// at a time and streams out each row's dot product.
`default_nettype none

module mvm_seq #(
   parameter int M = 4,
   parameter int N = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [11:0] s_data,
   input  logic        s_valid,
   output logic        s_ready,
   output logic [11:0] mac_a,
   output logic [11:0] mac_b,
   output logic        mac_valid,
   output logic        mac_clr,
   input  logic [23:0] mac_f,
   input  logic        mac_valid_out,
   output logic [23:0] m_data,
   output logic        m_valid,
   input  logic        m_ready
);

   localparam int DEPTH = M * N + N;
   localparam int KW    = $clog2(DEPTH);
   localparam int RW    = (M > 1) ? $clog2(M) : 1;
   localparam int JW    = (N > 1) ? $clog2(N) : 1;

   localparam logic [KW-1:0] K_LAST = KW'(DEPTH - 1);
   localparam logic [KW-1:0] X_BASE = KW'(M * N);
   localparam logic [KW-1:0] N_K    = KW'(N);
   localparam logic [RW-1:0] R_LAST = RW'(M - 1);
   localparam logic [JW-1:0] J_LAST = JW'(N - 1);

   typedef enum logic [2:0] {
      ST_LOAD   = 3'd0,
      ST_CLEAR  = 3'd1,
      ST_ISSUE  = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_OUTPUT = 3'd4
   } state_t;

   state_t          state;
   logic [KW-1:0]   k;
   logic [RW-1:0]   r;
   logic [JW-1:0]   j;
   logic [JW-1:0]   p;

   // Matrix row-major at 0..M*N-1, vector at M*N..M*N+N-1: load counter is the address.
   logic [11:0]     mem [DEPTH];

   logic [JW-1:0]   col;
   logic [KW-1:0]   w_addr;
   logic [KW-1:0]   x_addr;
   logic            load_xfer;

   // Operands are registered one cycle ahead, so address the column about to be issued.
   always_comb begin
      col       = (state == ST_CLEAR) ? '0 : j + 1'b1;
      w_addr    = KW'(r) * N_K + KW'(col);
      x_addr    = X_BASE + KW'(col);
      load_xfer = s_valid & s_ready;
   end

   always_ff @(posedge clk) begin
      if (reset && load_xfer) begin
         mem[k] <= s_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= ST_LOAD;
         k         <= '0;
         r         <= '0;
         j         <= '0;
         p         <= '0;
         s_ready   <= 1'b0;
         mac_a     <= '0;
         mac_b     <= '0;
         mac_valid <= 1'b0;
         mac_clr   <= 1'b1;
         m_data    <= '0;
         m_valid   <= 1'b0;
      end else begin
         case (state)
            ST_LOAD: begin
               s_ready <= 1'b1;
               mac_clr <= 1'b0;
               if (load_xfer) begin
                  if (k == K_LAST) begin
                     k       <= '0;
                     r       <= '0;
                     s_ready <= 1'b0;
                     mac_clr <= 1'b1;
                     state   <= ST_CLEAR;
                  end else begin
                     k <= k + 1'b1;
                  end
               end
            end

            ST_CLEAR: begin
               mac_clr   <= 1'b0;
               j         <= '0;
               p         <= '0;
               mac_valid <= 1'b1;
               mac_a     <= mem[w_addr];
               mac_b     <= mem[x_addr];
               state     <= ST_ISSUE;
            end

            ST_ISSUE: begin
               if (mac_valid_out) begin
                  p <= p + 1'b1;
               end
               if (j == J_LAST) begin
                  mac_valid <= 1'b0;
                  mac_a     <= '0;
                  mac_b     <= '0;
                  state     <= ST_DRAIN;
               end else begin
                  j     <= j + 1'b1;
                  mac_a <= mem[w_addr];
                  mac_b <= mem[x_addr];
               end
            end

            ST_DRAIN: begin
               if (mac_valid_out) begin
                  if (p == J_LAST) begin
                     m_data  <= mac_f;
                     m_valid <= 1'b1;
                     state   <= ST_OUTPUT;
                  end else begin
                     p <= p + 1'b1;
                  end
               end
            end

            ST_OUTPUT: begin
               if (m_ready) begin
                  m_valid <= 1'b0;
                  if (r == R_LAST) begin
                     s_ready <= 1'b1;
                     state   <= ST_LOAD;
                  end else begin
                     r       <= r + 1'b1;
                     mac_clr <= 1'b1;
                     state   <= ST_CLEAR;
                  end
               end
            end

            default: begin
               state     <= ST_LOAD;
               s_ready   <= 1'b0;
               mac_valid <= 1'b0;
               mac_a     <= '0;
               mac_b     <= '0;
               mac_clr   <= 1'b1;
               m_valid   <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: doc/mvm_seq.md
# mvm_seq

Sequencer for the matrix-vector multiply datapath; sits directly upstream of the saturating MAC unit. Accepts an M×N matrix and an N-element vector over a ready/valid input stream and holds them in internal registers. For each row it clears the MAC, issues N operand pairs, and captures the row dot product when the MAC reports the final result. Results leave on a ready/valid output stream, row 0 first.

## Interface
- M, 4, matrix rows (≥1)
- N, 4, matrix columns / vector length (≥1)
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clk
- s_data  in  12  signed input element
- s_valid  in  1  s_data valid
- s_ready  out  1  block can accept s_data
- mac_a  out  12  signed matrix operand to MAC a
- mac_b  out  12  signed vector operand to MAC b
- mac_valid  out  1  to MAC valid_in
- mac_clr  out  1  to MAC active-high reset; clears MAC accumulator and pipeline
- mac_f  in  24  MAC result f (already saturated)
- mac_valid_out  in  1  MAC valid_out
- m_data  out  24  signed row result
- m_valid  out  1  m_data valid
- m_ready  in  1  consumer accepts m_data

## Operation
- Storage: W[M][N] and x[N], 12-bit signed registers; not cleared by reset.
- Load order: M·N matrix elements row-major (W[0][0], W[0][1], …), then x[0]..x[N-1].
- Transfer occurs on a cycle with s_valid & s_ready, m_valid & m_ready.
- States:
  - LOAD: s_ready=1. Each transfer is written at load counter k; k increments. After the transfer at k = M·N+N−1: k←0, r←0, go to CLEAR.
  - CLEAR: one cycle with mac_clr=1; j←0, pulse count p←0; go to ISSUE.
  - ISSUE: mac_valid=1, mac_a=W[r][j], mac_b=x[j] for N consecutive cycles (j=0..N−1); go to DRAIN.
  - DRAIN: mac_valid=0. Count mac_valid_out pulses in p. Counting spans both ISSUE and DRAIN. On the cycle mac_valid_out=1 with p=N−1, register mac_f into the output register and go to OUTPUT.
  - OUTPUT: m_valid=1. On transfer: if r=M−1, go to LOAD; else r←r+1 and go to CLEAR.
- s_ready=0 in all states except LOAD. s_valid outside LOAD is ignored.
- In every state except ISSUE: mac_valid=0 and mac_a/mac_b=0.
- mac_clr=1 in CLEAR and while reset is asserted; 0 otherwise.
- Arithmetic: no arithmetic in this block. mac_f passes through unmodified; MAC saturation to [−8388608, 8388607] is preserved.
- Counters: k is $clog2(M·N+N) bits; r, j, p are sized for M and N. No wrap beyond the stated limits.

## Timing
- Reset (reset=0 at an edge): state=LOAD, k=r=j=p=0, m_valid=0, m_data=0, mac_valid=0, mac_a=mac_b=0, mac_clr=1, s_ready=0 while reset is low. s_ready=1 on the first cycle after release.
- Reset mid-operation: any in-flight row and any pending m_data is discarded. The block returns to LOAD and requires a full reload.
- MAC pipeline: valid_in sampled at edge e produces valid_out high during the cycle after edge e+1. The final row result is therefore valid 2 cycles after the last ISSUE cycle.
- Per row: CLEAR (1 cycle) + ISSUE (N cycles) + DRAIN (2 cycles). m_valid rises N+3 cycles after CLEAR is entered (7 for N=4).
- Back-pressure: while m_valid=1 and m_ready=0, m_data is held stable and no new CLEAR/ISSUE starts. m_valid never drops without a transfer.
- Load bubbles: s_valid gaps only stall k; there is no timeout.
- The first CLEAR follows the final load transfer by exactly 1 cycle.

## Test plan
- W = I(4), x = [1,2,3,4], no stalls -> m_data = 1, 2, 3, 4 in order. Each m_valid appears 7 cycles after its CLEAR.
- Same data, m_ready held low 5 cycles on row 0 -> m_data = 1 held stable. mac_valid stays 0 until the transfer; remaining rows are correct.
- Row 0 all 2047 with x all 2047 -> 8388607. Row 1 all −2048 with x all 2047 -> −8388608.
- Random s_valid bubbles during load; s_valid=1 asserted during ISSUE -> results identical to the bubble-free run. Extra data is not consumed (s_ready=0).
- reset=0 during ISSUE of row 1 -> next cycle m_valid=0, mac_clr=1. After release: s_ready=1; a fresh load of W=I, x=[5,6,7,8] gives 5, 6, 7, 8.
- Two back-to-back loads: second matrix all 1, x = [1,1,1,1] -> four outputs of 4. No accumulation carries over from the previous row or matrix.
